// File: rtl/board_fetch_sched.sv
// rtl/board_fetch_sched.sv - board RAM arbiter with hblank row prefetch and per-pixel cell lookup
module board_fetch_sched #(
    parameter int SIZE     = 52,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        wr_req,
    input  logic [6:0]  wr_idx,
    input  logic [3:0]  wr_val,
    output logic        wr_ack,
    output logic [6:0]  ram_addr,
    output logic        ram_we,
    output logic [3:0]  ram_wdata,
    input  logic [3:0]  ram_rdata,
    output logic        cell_hit,
    output logic [3:0]  cell_digit,
    output logic [11:0] num_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

    function automatic logic [9:0] cell_pos(input logic [3:0] i);
        case (i)
            4'd0:    cell_pos = 10'd0;
            4'd1:    cell_pos = 10'd53;
            4'd2:    cell_pos = 10'd106;
            4'd3:    cell_pos = 10'd161;
            4'd4:    cell_pos = 10'd214;
            4'd5:    cell_pos = 10'd267;
            4'd6:    cell_pos = 10'd322;
            4'd7:    cell_pos = 10'd375;
            default: cell_pos = 10'd428;
        endcase
    endfunction

    // Returns {hit, index}; gaps between cells and anything past the board miss.
    function automatic logic [4:0] lookup(input logic [9:0] p);
        lookup = '0;
        for (int i = 0; i < 9; i++) begin
            if (p >= cell_pos(4'(i)) && p < cell_pos(4'(i)) + 10'(SIZE))
                lookup = {1'b1, 4'(i)};
        end
    endfunction

    state_t      state, state_nx;
    logic [9:0]  h_prev;
    logic [3:0]  k;
    logic [3:0]  fetch_row;
    logic        fetch_pend;
    logic [3:0]  shadow [9];
    logic        shadow_valid;
    logic [3:0]  shadow_row;
    logic [3:0]  active [9];
    logic        act_valid;
    logic [3:0]  act_row;

    logic        trig, swap;
    logic [9:0]  next_y;
    logic        ny_ok;
    logic [3:0]  ny_row;
    logic        hc_ok, vr_ok;
    logic [3:0]  hc_col, vr_row;
    logic        pix_hit;
    logic [11:0] dy, dx;

    assign trig   = (h_cnt == 10'(H_ACTIVE)) && (h_prev != 10'(H_ACTIVE));
    assign swap   = (h_cnt == 10'd0) && (h_prev != 10'd0);
    assign next_y = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    assign {ny_ok, ny_row} = lookup(next_y);
    assign {hc_ok, hc_col} = lookup(h_cnt);
    assign {vr_ok, vr_row} = lookup(v_cnt);
    assign pix_hit = act_valid && hc_ok && vr_ok && (vr_row == act_row);
    assign dy      = 12'(v_cnt - cell_pos(vr_row));
    assign dx      = 12'(h_cnt - cell_pos(hc_col));

    always_comb begin
        state_nx  = state;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        wr_ack    = 1'b0;
        case (state)
            IDLE: begin
                if ((trig && ny_ok) || fetch_pend) state_nx = FETCH;
                else if (wr_req)                   state_nx = WRITE;
            end
            FETCH: begin
                ram_addr = 7'(fetch_row) * 7'd9 + 7'(k);
                if (k == 4'd8) state_nx = DRAIN;
            end
            DRAIN: state_nx = IDLE;
            WRITE: begin
                ram_addr  = wr_idx;
                ram_wdata = wr_val;
                ram_we    = (wr_idx < 7'd81);
                wr_ack    = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // h_prev tracks through reset so a held h_cnt does not retrigger afterwards.
    always_ff @(posedge clk) h_prev <= h_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            fetch_row    <= '0;
            fetch_pend   <= 1'b0;
            shadow_valid <= 1'b0;
            shadow_row   <= '0;
            act_valid    <= 1'b0;
            act_row      <= '0;
            cell_hit     <= 1'b0;
            cell_digit   <= '0;
            num_addr     <= '0;
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (trig) begin
                shadow_valid <= 1'b0;
                if (ny_ok) begin
                    fetch_row <= ny_row;
                    if (state != IDLE) fetch_pend <= 1'b1;
                end
            end
            if (state == IDLE && state_nx == FETCH) begin
                k          <= '0;
                fetch_pend <= 1'b0;
            end
            if (state == FETCH) begin
                k <= k + 4'd1;
                if (k != 4'd0) shadow[k - 4'd1] <= ram_rdata;
            end
            if (state == DRAIN) begin
                shadow[8]    <= ram_rdata;
                shadow_valid <= 1'b1;
                shadow_row   <= fetch_row;
            end
            if (swap) begin
                for (int i = 0; i < 9; i++) active[i] <= shadow[i];
                act_valid <= shadow_valid;
                act_row   <= shadow_row;
            end
            cell_hit   <= pix_hit;
            cell_digit <= pix_hit ? active[hc_col] : 4'd0;
            num_addr   <= pix_hit ? dy * 12'(SIZE) + dx : 12'd0;
        end
    end

endmodule

// File: tb/tb_board_fetch_sched.sv
// tb/tb_board_fetch_sched.sv - directed self-checking bench for board_fetch_sched
module tb_board_fetch_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        wr_req;
    logic [6:0]  wr_idx;
    logic [3:0]  wr_val;
    logic        wr_ack;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata;
    logic        cell_hit;
    logic [3:0]  cell_digit;
    logic [11:0] num_addr;

    logic [3:0]  mem [128];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    board_fetch_sched dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_val(wr_val), .wr_ack(wr_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cell_hit(cell_hit), .cell_digit(cell_digit), .num_addr(num_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_row(input logic [9:0] v, input int base);
        h_cnt = 10'd639; v_cnt = v; step();
        h_cnt = 10'd640; step();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("fetch_addr_%0d", base + k), 32'(ram_addr), 32'(base + k));
            check("fetch_we", 32'(ram_we), 0);
            step();
        end
        check("drain_we", 32'(ram_we), 0);
        step();
    endtask

    task automatic swap_to(input logic [9:0] v);
        h_cnt = 10'd0; v_cnt = v; step();
    endtask

    task automatic pix_chk(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input int hit, input int dig, input int addr);
        h_cnt = h; v_cnt = v; step();
        check({tag, "_hit"}, 32'(cell_hit), 32'(hit));
        check({tag, "_digit"}, 32'(cell_digit), 32'(dig));
        check({tag, "_naddr"}, 32'(num_addr), 32'(addr));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 4'd0;
        for (int i = 0; i < 9; i++) mem[i] = 4'(i + 1);
        for (int i = 0; i < 9; i++) mem[9 + i] = 4'(9 - i);
        for (int i = 0; i < 8; i++) mem[72 + i] = 4'(i + 1);
        rst = 1'b1; h_cnt = '0; v_cnt = '0; wr_req = 1'b0; wr_idx = '0; wr_val = '0;
        step(); step();
        check("rst_hit", 32'(cell_hit), 0);
        check("rst_digit", 32'(cell_digit), 0);
        check("rst_naddr", 32'(num_addr), 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_ack", 32'(wr_ack), 0);
        check("rst_addr", 32'(ram_addr), 0);

        // Reset in the middle of a burst
        rst = 1'b0;
        h_cnt = 10'd639; v_cnt = 10'd524; step();
        h_cnt = 10'd640; step();
        check("burst_k0", 32'(ram_addr), 0);
        step(); step();
        check("burst_k2", 32'(ram_addr), 2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_addr", 32'(ram_addr), 0);
            check("midrst_we", 32'(ram_we), 0);
            check("midrst_ack", 32'(wr_ack), 0);
        end
        rst = 1'b0;
        step();
        check("post_rst_idle", 32'(ram_addr), 0);

        // Row 0 via v_cnt wrap
        fetch_row(10'd524, 0);
        swap_to(10'd0);
        pix_chk("r0c0", 10'd0, 10'd0, 1, 1, 0);
        pix_chk("gap_col", 10'd52, 10'd0, 0, 0, 0);
        pix_chk("r0c1", 10'd53, 10'd0, 1, 2, 0);
        pix_chk("r0c1_off", 10'd60, 10'd3, 1, 2, 163);
        pix_chk("r0_wrong_v", 10'd53, 10'd53, 0, 0, 0);

        // Row 1
        fetch_row(10'd52, 9);
        swap_to(10'd53);
        pix_chk("r1c0", 10'd0, 10'd53, 1, 9, 0);
        pix_chk("r1c2", 10'd110, 10'd60, 1, 7, 368);

        // Gap line: no RAM traffic and nothing drawn
        h_cnt = 10'd639; v_cnt = 10'd104; step();
        h_cnt = 10'd640; step();
        for (int i = 0; i < 10; i++) begin
            check("gap_addr", 32'(ram_addr), 0);
            check("gap_we", 32'(ram_we), 0);
            step();
        end
        swap_to(10'd105);
        pix_chk("gap_h0", 10'd0, 10'd105, 0, 0, 0);
        pix_chk("gap_h53", 10'd53, 10'd105, 0, 0, 0);
        pix_chk("gap_h300", 10'd300, 10'd105, 0, 0, 0);

        // Write colliding with trigger: fetch wins, write acked 12 cycles later
        h_cnt = 10'd639; v_cnt = 10'd213; step();
        h_cnt = 10'd640; wr_req = 1'b1; wr_idx = 7'd40; wr_val = 4'd7;
        step();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("coll_addr_%0d", 36 + k), 32'(ram_addr), 32'(36 + k));
            check("coll_ack_wait", 32'(wr_ack), 0);
            step();
        end
        check("coll_drain_ack", 32'(wr_ack), 0);
        check("coll_drain_we", 32'(ram_we), 0);
        step();
        check("coll_idle_ack", 32'(wr_ack), 0);
        step();
        check("coll_ack", 32'(wr_ack), 1);
        check("coll_we", 32'(ram_we), 1);
        check("coll_addr", 32'(ram_addr), 40);
        check("coll_wdata", 32'(ram_wdata), 7);
        wr_req = 1'b0;
        step();
        check("coll_ack_drop", 32'(wr_ack), 0);
        check("coll_mem", 32'(mem[40]), 7);

        // Idle write, no back-to-back ack while request stays high
        wr_req = 1'b1; wr_idx = 7'd80; wr_val = 4'd5;
        step();
        check("idle_ack", 32'(wr_ack), 1);
        check("idle_we", 32'(ram_we), 1);
        check("idle_addr", 32'(ram_addr), 80);
        check("idle_wdata", 32'(ram_wdata), 5);
        step();
        check("no_b2b_ack", 32'(wr_ack), 0);
        wr_req = 1'b0;
        step();
        check("idle_mem", 32'(mem[80]), 5);

        // Out-of-range index: ack without write
        wr_req = 1'b1; wr_idx = 7'd81; wr_val = 4'd3;
        step();
        check("oob_ack", 32'(wr_ack), 1);
        check("oob_we", 32'(ram_we), 0);
        wr_req = 1'b0;
        step();
        check("oob_ack_drop", 32'(wr_ack), 0);

        // Coherency: write after fetch stays invisible until refetch
        fetch_row(10'd524, 0);
        swap_to(10'd0);
        pix_chk("coh_before", 10'd0, 10'd10, 1, 1, 520);
        wr_req = 1'b1; wr_idx = 7'd0; wr_val = 4'd4;
        step();
        check("coh_ack", 32'(wr_ack), 1);
        wr_req = 1'b0;
        step();
        pix_chk("coh_stale", 10'd0, 10'd10, 1, 1, 520);
        fetch_row(10'd524, 0);
        swap_to(10'd0);
        pix_chk("coh_new", 10'd0, 10'd10, 1, 4, 520);

        // Row 8 corner glyph address and right edge
        fetch_row(10'd427, 72);
        swap_to(10'd428);
        pix_chk("r8c0", 10'd0, 10'd428, 1, 1, 0);
        pix_chk("r8c8", 10'd479, 10'd479, 1, 5, 2703);
        pix_chk("r8_h480", 10'd480, 10'd479, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
